// File: rtl/pcpi_pkg.sv
// Shared types and constants for the PCPI dispatcher and coprocessor wrappers.
package pcpi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DONE,
        ST_COOL
    } state_e;

    typedef enum logic [1:0] {
        SEL_MUL,
        SEL_DIV,
        SEL_NONE
    } sel_e;

    // M-extension match: opcode bits [6:4] and [2:0], plus funct7
    localparam logic [2:0] M_OPC_HI = 3'b011;
    localparam logic [2:0] M_OPC_LO = 3'b011;
    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/pcpi_decode.sv
// Combinational instruction decode: picks the coprocessor target for an insn.
module pcpi_decode
    import pcpi_pkg::*;
(
    input  logic [31:0] insn,
    output sel_e        sel
);

    logic is_m;
    logic unused_insn;

    assign is_m = (insn[6:4] == M_OPC_HI) && (insn[2:0] == M_OPC_LO) &&
                  (insn[31:25] == M_FUNCT7);

    assign unused_insn = ^{insn[24:15], insn[13:7], insn[3]};

    // funct3[2] splits MUL* from DIV*/REM*
    always_comb begin
        sel = SEL_NONE;
        if (is_m) begin
            sel = insn[14] ? SEL_DIV : SEL_MUL;
        end
    end

endmodule

// File: rtl/pcpi_dispatch.sv
// PCPI dispatcher: routes core requests to the multiplier or divider.
// Optional response timeout enabled by defining PCPI_DISPATCH_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for core_valid; request latched on accept
// ST_ISSUE | selected target valid held high until it answers
// ST_DONE  | one-cycle core_ready pulse with the captured response
// ST_COOL  | one dead cycle so a still-high core_valid cannot re-trigger
module pcpi_dispatch
    import pcpi_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 127
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            core_valid,
    input  logic [31:0]     core_insn,
    input  logic [XLEN-1:0] core_rs1,
    input  logic [XLEN-1:0] core_rs2,
    output logic            core_ready,
    output logic            core_wb_write,
    output logic [XLEN-1:0] core_wb_data,
    output logic            core_illegal,
    output logic [31:0]     cop_insn,
    output logic [XLEN-1:0] cop_rs1,
    output logic [XLEN-1:0] cop_rs2,
    output logic            mul_valid,
    output logic            div_valid,
    input  logic            mul_ready,
    input  logic            mul_wr,
    input  logic [XLEN-1:0] mul_rd,
    input  logic            div_ready,
    input  logic            div_wr,
    input  logic [XLEN-1:0] div_rd,
    output logic            busy
);

    state_e          state_q, state_d;
    sel_e            sel_q, sel_d, dec_sel;
    logic [31:0]     insn_q, insn_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            wr_q, wr_d, ill_q, ill_d;
    logic            tgt_ready, tgt_wr, timed_out;
    logic [XLEN-1:0] tgt_rd;

    pcpi_decode u_decode (
        .insn (core_insn),
        .sel  (dec_sel)
    );

`ifdef PCPI_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    // Fires in the TIMEOUT-th ISSUE cycle, so the valid is high for TIMEOUT cycles
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_ISSUE) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign timed_out = 1'b0;
`endif

    // Only the selected target is listened to
    always_comb begin
        tgt_ready = 1'b0;
        tgt_wr    = 1'b0;
        tgt_rd    = '0;
        if (sel_q == SEL_MUL) begin
            tgt_ready = mul_ready;
            tgt_wr    = mul_wr;
            tgt_rd    = mul_rd;
        end else if (sel_q == SEL_DIV) begin
            tgt_ready = div_ready;
            tgt_wr    = div_wr;
            tgt_rd    = div_rd;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        insn_d  = insn_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        data_d  = data_q;
        wr_d    = wr_q;
        ill_d   = ill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (core_valid) begin
                    insn_d = core_insn;
                    rs1_d  = core_rs1;
                    rs2_d  = core_rs2;
                    sel_d  = dec_sel;
                    if (dec_sel == SEL_NONE) begin
                        state_d = ST_DONE;
                        wr_d    = 1'b0;
                        data_d  = '0;
                        ill_d   = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (tgt_ready) begin
                    state_d = ST_DONE;
                    wr_d    = tgt_wr;
                    data_d  = tgt_rd;
                    ill_d   = 1'b0;
                end else if (timed_out) begin
                    state_d = ST_DONE;
                    wr_d    = 1'b0;
                    data_d  = '0;
                    ill_d   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_COOL;
            ST_COOL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_NONE;
            insn_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            insn_q  <= insn_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            ill_q   <= ill_d;
        end
    end

    assign core_ready    = (state_q == ST_DONE);
    assign core_wb_write = core_ready & wr_q;
    assign core_illegal  = core_ready & ill_q;
    assign core_wb_data  = core_ready ? data_q : '0;
    assign cop_insn      = insn_q;
    assign cop_rs1       = rs1_q;
    assign cop_rs2       = rs2_q;
    assign mul_valid     = (state_q == ST_ISSUE) && (sel_q == SEL_MUL);
    assign div_valid     = (state_q == ST_ISSUE) && (sel_q == SEL_DIV);
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcpi_dispatch.sv
// Directed bench for pcpi_dispatch; define PCPI_DISPATCH_TIMEOUT_EN for the timeout build.
module tb_pcpi_dispatch;

    localparam int XLEN = 64;

    logic            clock = 1'b0;
    logic            reset;
    logic            core_valid;
    logic [31:0]     core_insn;
    logic [XLEN-1:0] core_rs1, core_rs2;
    logic            core_ready, core_wb_write, core_illegal;
    logic [XLEN-1:0] core_wb_data;
    logic [31:0]     cop_insn;
    logic [XLEN-1:0] cop_rs1, cop_rs2;
    logic            mul_valid, div_valid;
    logic            mul_ready, mul_wr, div_ready, div_wr;
    logic [XLEN-1:0] mul_rd, div_rd;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int mul_seen = 0, div_seen = 0, both_seen = 0, leak_seen = 0, ready_seen = 0;

    pcpi_dispatch #(.XLEN(XLEN), .TIMEOUT(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .core_valid    (core_valid),
        .core_insn     (core_insn),
        .core_rs1      (core_rs1),
        .core_rs2      (core_rs2),
        .core_ready    (core_ready),
        .core_wb_write (core_wb_write),
        .core_wb_data  (core_wb_data),
        .core_illegal  (core_illegal),
        .cop_insn      (cop_insn),
        .cop_rs1       (cop_rs1),
        .cop_rs2       (cop_rs2),
        .mul_valid     (mul_valid),
        .div_valid     (div_valid),
        .mul_ready     (mul_ready),
        .mul_wr        (mul_wr),
        .mul_rd        (mul_rd),
        .div_ready     (div_ready),
        .div_wr        (div_wr),
        .div_rd        (div_rd),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mul_valid) mul_seen++;
        if (div_valid) div_seen++;
        if (mul_valid && div_valid) both_seen++;
        if (core_ready) ready_seen++;
        if (!core_ready && (core_wb_write || core_illegal || core_wb_data != '0)) leak_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_targets();
        mul_ready = 0; mul_wr = 0; mul_rd = '0;
        div_ready = 0; div_wr = 0; div_rd = '0;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int m0, d0, r0, n;
        reset = 1; core_valid = 0; core_insn = '0; core_rs1 = '0; core_rs2 = '0;
        quiet_targets();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_ready", core_ready, 0);
        chk("rst_mulv", mul_valid, 0);
        chk("rst_divv", div_valid, 0);
        chk("rst_cop_insn", cop_insn, 0);
        chk("rst_wb_data", core_wb_data, 0);
        reset = 0;
        tick();

        // MUL 6*7 with a stray divider response that must be ignored
        d0 = div_seen;
        core_valid = 1; core_insn = 32'h02B50533; core_rs1 = 6; core_rs2 = 7;
        tick();
        core_valid = 0; core_insn = '0; core_rs1 = '0; core_rs2 = '0;
        chk("mul_issue_mulv", mul_valid, 1);
        chk("mul_issue_divv", div_valid, 0);
        chk("mul_cop_insn", cop_insn, 32'h02B50533);
        chk("mul_cop_rs1", cop_rs1, 6);
        chk("mul_cop_rs2", cop_rs2, 7);
        div_ready = 1; div_wr = 1; div_rd = 99;
        tick();
        chk("mul_ignores_div", core_ready, 0);
        chk("mul_still_valid", mul_valid, 1);
        mul_ready = 1; mul_wr = 1; mul_rd = 42;
        tick();
        quiet_targets();
        chk("mul_ready", core_ready, 1);
        chk("mul_wb_write", core_wb_write, 1);
        chk("mul_wb_data", core_wb_data, 42);
        chk("mul_illegal", core_illegal, 0);
        chk("mul_valid_drop", mul_valid, 0);
        tick();
        chk("mul_cool_ready", core_ready, 0);
        chk("mul_cool_busy", busy, 1);
        tick();
        chk("mul_idle", busy, 0);
        chk("mul_no_divv", div_seen - d0, 0);

        // DIVU 100/7 with a stray multiplier response
        m0 = mul_seen;
        core_valid = 1; core_insn = 32'h02B55533; core_rs1 = 100; core_rs2 = 7;
        tick();
        core_valid = 0;
        chk("div_issue_divv", div_valid, 1);
        mul_ready = 1; mul_wr = 1; mul_rd = 55;
        tick();
        chk("div_ignores_mul", core_ready, 0);
        div_ready = 1; div_wr = 1; div_rd = 14;
        tick();
        quiet_targets();
        chk("div_ready", core_ready, 1);
        chk("div_wb_data", core_wb_data, 14);
        chk("div_wb_write", core_wb_write, 1);
        drain();
        chk("div_no_mulv", mul_seen - m0, 0);

        // Non-M instruction
        m0 = mul_seen; d0 = div_seen;
        core_valid = 1; core_insn = 32'h00B50533; core_rs1 = 3; core_rs2 = 4;
        tick();
        core_valid = 0;
        chk("ill_ready", core_ready, 1);
        chk("ill_illegal", core_illegal, 1);
        chk("ill_wb_write", core_wb_write, 0);
        chk("ill_wb_data", core_wb_data, 0);
        chk("ill_cop_insn", cop_insn, 32'h00B50533);
        drain();
        chk("ill_no_valids", (mul_seen - m0) + (div_seen - d0), 0);

        // core_valid and mul_ready held high: next accept exactly 4 edges later
        core_valid = 1; core_insn = 32'h02B50533; core_rs1 = 2; core_rs2 = 3;
        mul_ready = 1; mul_wr = 1; mul_rd = 5;
        tick();
        chk("hold_issue", mul_valid, 1);
        tick();
        chk("hold_done", core_ready, 1);
        chk("hold_data", core_wb_data, 5);
        tick();
        chk("hold_cool_mulv", mul_valid, 0);
        chk("hold_cool_busy", busy, 1);
        tick();
        chk("hold_idle", busy, 0);
        tick();
        chk("hold_reissue", mul_valid, 1);
        core_valid = 0;
        tick();
        quiet_targets();
        drain();

        // Divider never answers
        core_valid = 1; core_insn = 32'h02B55533; core_rs1 = 9; core_rs2 = 0;
        tick();
        core_valid = 0;
`ifdef PCPI_DISPATCH_TIMEOUT_EN
        n = 0;
        while (div_valid && n < 50) begin
            n++;
            tick();
        end
        chk("to_issue_cycles", n, 8);
        chk("to_ready", core_ready, 1);
        chk("to_illegal", core_illegal, 1);
        chk("to_wb_write", core_wb_write, 0);
        chk("to_divv_drop", div_valid, 0);
        drain();
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nto_busy", busy, 1);
        chk("nto_divv", div_valid, 1);
        reset = 1;
        tick();
        reset = 0;
        chk("nto_reset_busy", busy, 0);
`endif

        // Reset three cycles into ISSUE, then a late divider answer
        core_valid = 1; core_insn = 32'h02B55533; core_rs1 = 100; core_rs2 = 7;
        tick();
        core_valid = 0;
        tick(); tick();
        chk("rmid_divv", div_valid, 1);
        r0 = ready_seen;
        reset = 1;
        tick();
        reset = 0;
        chk("rmid_divv_0", div_valid, 0);
        chk("rmid_busy_0", busy, 0);
        chk("rmid_cop_insn_0", cop_insn, 0);
        chk("rmid_cop_rs1_0", cop_rs1, 0);
        chk("rmid_ready_0", core_ready, 0);
        div_ready = 1; div_wr = 1; div_rd = 77;
        tick(); tick(); tick();
        quiet_targets();
        chk("rmid_no_ready", ready_seen - r0, 0);
        chk("rmid_idle", busy, 0);

        chk("never_both_valid", both_seen, 0);
        chk("no_resp_leak", leak_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
